// File: rtl/jtkiwi_romrq_pkg.sv
// Shared types and defaults for the Kiwi graphics ROM request responder.
// JTKIWI_ROMRQ_CACHE2_EN selects a two-entry cache instead of one entry.
package jtkiwi_romrq_pkg;

  localparam int AW_DEF  = 20;
  localparam int SDW_DEF = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RD0  = 2'd2,
    RD1  = 2'd3
  } state_t;

  typedef struct packed {
    logic [AW_DEF-1:0] tag;
    logic [31:0]       data;
    logic              valid;
  } entry_t;

`ifdef JTKIWI_ROMRQ_CACHE2_EN
  localparam int ENTRIES = 2;
`else
  localparam int ENTRIES = 1;
`endif

endpackage

// File: rtl/jtkiwi_romrq_cache.sv
// Tag cache for jtkiwi_gfx_romrq: lookup, fill and replacement.
// JTKIWI_ROMRQ_CACHE2_EN gives two entries with a round-robin fill pointer.
module jtkiwi_romrq_cache
  import jtkiwi_romrq_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] look_addr,
  output logic          hit,
  output logic [31:0]   hit_data,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_addr,
  input  logic [31:0]   fill_data
);

  entry_t entry_q [ENTRIES];
  entry_t entry_d [ENTRIES];

  function automatic logic [AW_DEF-1:0] tag_of(input logic [AW-1:0] a);
    return AW_DEF'(a);
  endfunction

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entry_q[i].valid && (entry_q[i].tag == tag_of(look_addr))) begin
        hit      = 1'b1;
        hit_data = entry_q[i].data;
      end
    end
  end

`ifdef JTKIWI_ROMRQ_CACHE2_EN
  logic ptr_q;
  logic ptr_d;

  // With two entries the pointer always lands on the older line.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < ENTRIES; i++) entry_d[i] = entry_q[i];
    if (fill_en) begin
      entry_d[ptr_q] = '{tag: tag_of(fill_addr), data: fill_data, valid: 1'b1};
      ptr_d          = ~ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    entry_d[0] = entry_q[0];
    if (fill_en) begin
      entry_d[0] = '{tag: tag_of(fill_addr), data: fill_data, valid: 1'b1};
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: rtl/jtkiwi_gfx_romrq.sv
// Graphics ROM request responder: answers 32-bit reads from a tag cache and
// fills misses with two 16-bit SDRAM reads. Cache size set by JTKIWI_ROMRQ_CACHE2_EN.
module jtkiwi_gfx_romrq
  import jtkiwi_romrq_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int SDW = SDW_DEF
) (
  input  logic           rst,
  input  logic           clk,
  input  logic           rom_cs,
  input  logic [AW-1:0]  rom_addr,
  output logic [31:0]    rom_data,
  output logic           rom_ok,
  output logic           sdram_req,
  output logic [SDW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           sdram_dst,
  input  logic [15:0]    sdram_din
);

  state_t         state_q, state_d;
  logic [AW-1:0]  line_addr_q, line_addr_d;
  logic [15:0]    low_q, low_d;
  logic           rom_ok_q, rom_ok_d;
  logic [31:0]    rom_data_q, rom_data_d;

  logic           hit;
  logic [31:0]    hit_data;
  logic           fill_en;

  jtkiwi_romrq_cache #(
    .AW (AW)
  ) u_cache (
    .clk       (clk),
    .rst       (rst),
    .look_addr (rom_addr),
    .hit       (hit),
    .hit_data  (hit_data),
    .fill_en   (fill_en),
    .fill_addr (line_addr_q),
    .fill_data ({sdram_din, low_q})
  );

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    low_d       = low_q;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rom_cs && !hit) begin
          line_addr_d = rom_addr;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) state_d = RD0;
      end
      RD0: begin
        if (sdram_dst) begin
          low_d   = sdram_din;
          state_d = RD1;
        end
      end
      RD1: begin
        if (sdram_dst) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The hit path runs regardless of any fetch in flight.
    rom_ok_d   = rom_cs & hit;
    rom_data_d = hit ? hit_data : rom_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      low_q       <= '0;
      rom_ok_q    <= 1'b0;
      rom_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      low_q       <= low_d;
      rom_ok_q    <= rom_ok_d;
      rom_data_q  <= rom_data_d;
    end
  end

  // line_addr only moves on a miss in IDLE, so the SDRAM address holds for the whole fetch.
  assign sdram_req  = (state_q == REQ);
  assign sdram_addr = SDW'({line_addr_q, 1'b0});
  assign rom_ok     = rom_ok_q;
  assign rom_data   = rom_data_q;

endmodule

// File: tb/tb_jtkiwi_gfx_romrq.sv
// Bench for jtkiwi_gfx_romrq: directed scenarios, then random traffic against a FIFO line model.
module tb_jtkiwi_gfx_romrq;

  localparam int AW  = 20;
  localparam int SDW = 21;
`ifdef JTKIWI_ROMRQ_CACHE2_EN
  localparam int NENT = 2;
`else
  localparam int NENT = 1;
`endif

  logic           clk;
  logic           rst;
  logic           rom_cs;
  logic [AW-1:0]  rom_addr;
  logic [31:0]    rom_data;
  logic           rom_ok;
  logic           sdram_req;
  logic [SDW-1:0] sdram_addr;
  logic           sdram_ack;
  logic           sdram_dst;
  logic [15:0]    sdram_din;

  int errs   = 0;
  int checks = 0;

  jtkiwi_gfx_romrq #(.AW(AW), .SDW(SDW)) dut (
    .rst        (rst),
    .clk        (clk),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_din  (sdram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] mem16(input logic [SDW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'h9E3779B1 + 32'h1234_5678;
    return t[31:16];
  endfunction

  task automatic fetch(input string tg, input logic [AW-1:0] a,
                       input logic [15:0] lo, input logic [15:0] hi);
    rom_cs   = 1'b1;
    rom_addr = a;
    step();
    chk({tg, "_req"}, sdram_req, 1'b1);
    chk({tg, "_addr"}, sdram_addr, {a, 1'b0});
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = lo;
    step();
    sdram_din = hi;
    step();
    sdram_dst = 1'b0;
    step();
    chk({tg, "_ok"}, rom_ok, 1'b1);
    chk({tg, "_data"}, rom_data, {hi, lo});
  endtask

  // Random-phase model state
  logic [AW-1:0]  m_tag [$];
  logic [31:0]    m_dat [$];
  logic [AW-1:0]  pool [6];
  logic           req_pend, in_data, exp_ok, m_hit;
  logic [31:0]    exp_data, m_hdat;
  logic [AW-1:0]  line;
  logic [15:0]    lowhalf;
  int             dcount, ack_wait;

  initial begin
    rst       = 1'b1;
    rom_cs    = 1'b0;
    rom_addr  = '0;
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    sdram_din = '0;
    repeat (2) @(negedge clk);
    chk("rst_ok", rom_ok, 1'b0);
    chk("rst_data", rom_data, 32'h0);
    chk("rst_req", sdram_req, 1'b0);
    chk("rst_addr", sdram_addr, 21'h0);
    rst = 1'b0;

    // Reset in the middle of RD0 abandons the fetch
    rom_cs   = 1'b1;
    rom_addr = 20'h00123;
    step();
    chk("rd0rst_req", sdram_req, 1'b1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    chk("rd0rst_req_drop", sdram_req, 1'b0);
    rst    = 1'b1;
    rom_cs = 1'b0;
    #1;
    chk("rd0rst_req0", sdram_req, 1'b0);
    chk("rd0rst_ok0", rom_ok, 1'b0);
    step();
    rst       = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = 16'h1111;
    step();
    sdram_din = 16'h2222;
    step();
    sdram_dst = 1'b0;

    // Same address now misses; this is also the cold-miss latency case
    rom_cs   = 1'b1;
    rom_addr = 20'h00123;
    step();
    chk("cold_req", sdram_req, 1'b1);
    chk("cold_addr", sdram_addr, 21'h000246);
    chk("cold_ok_e0", rom_ok, 1'b0);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = 16'hBEEF;
    step();
    sdram_din = 16'hDEAD;
    step();
    sdram_dst = 1'b0;
    chk("cold_ok_e3", rom_ok, 1'b0);
    step();
    chk("cold_ok_e4", rom_ok, 1'b1);
    chk("cold_data", rom_data, 32'hDEADBEEF);
    chk("cold_req_done", sdram_req, 1'b0);

    // Hit after rom_cs toggles
    rom_cs = 1'b0;
    step();
    chk("hit_cs0", rom_ok, 1'b0);
    rom_cs = 1'b1;
    step();
    chk("hit_ok", rom_ok, 1'b1);
    chk("hit_req", sdram_req, 1'b0);
    chk("hit_data", rom_data, 32'hDEADBEEF);

    // Address change during RD0
    rom_addr = 20'h00777;
    step();
    chk("chg_addr1", sdram_addr, 21'h000EEE);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    rom_addr  = 20'h00456;
    sdram_dst = 1'b1;
    sdram_din = 16'h1111;
    step();
    chk("chg_ok_rd", rom_ok, 1'b0);
    sdram_din = 16'h2222;
    step();
    sdram_dst = 1'b0;
    chk("chg_ok_fill", rom_ok, 1'b0);
    chk("chg_req_gap", sdram_req, 1'b0);
    step();
    chk("chg_req2", sdram_req, 1'b1);
    chk("chg_addr2", sdram_addr, 21'h0008AC);
    chk("chg_ok_req2", rom_ok, 1'b0);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = 16'h3333;
    step();
    sdram_din = 16'h4444;
    step();
    sdram_dst = 1'b0;
    chk("chg_ok_fill2", rom_ok, 1'b0);
    step();
    chk("chg_ok_done", rom_ok, 1'b1);
    chk("chg_data", rom_data, 32'h44443333);

    // rom_cs drop during the fetch
    rom_addr = 20'h00999;
    step();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    rom_cs    = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = 16'h5555;
    step();
    chk("csdrop_ok_rd", rom_ok, 1'b0);
    sdram_din = 16'h6666;
    step();
    sdram_dst = 1'b0;
    step();
    chk("csdrop_ok_after", rom_ok, 1'b0);
    rom_cs = 1'b1;
    step();
    chk("csdrop_hit", rom_ok, 1'b1);
    chk("csdrop_req", sdram_req, 1'b0);
    chk("csdrop_data", rom_data, 32'h66665555);

`ifdef JTKIWI_ROMRQ_CACHE2_EN
    fetch("c2_a", 20'h00010, 16'hA0A0, 16'hA1A1);
    fetch("c2_b", 20'h00020, 16'hB0B0, 16'hB1B1);
    rom_addr = 20'h00010;
    step();
    chk("c2_a_hit_req", sdram_req, 1'b0);
    chk("c2_a_hit_ok", rom_ok, 1'b1);
    chk("c2_a_hit_data", rom_data, 32'hA1A1A0A0);
    fetch("c2_c", 20'h00030, 16'hC0C0, 16'hC1C1);
    rom_addr = 20'h00010;
    step();
    chk("c2_a_miss_req", sdram_req, 1'b1);
    chk("c2_a_miss_ok", rom_ok, 1'b0);
`else
    fetch("c1_a", 20'h00010, 16'hA0A0, 16'hA1A1);
    rom_addr = 20'h00999;
    step();
    chk("c1_evict_req", sdram_req, 1'b1);
`endif

    // Random traffic against the line model
    rom_cs = 1'b0;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) pool[i] = AW'($urandom);
    m_tag.delete();
    m_dat.delete();
    req_pend = 1'b0;
    in_data  = 1'b0;
    exp_ok   = 1'b0;
    exp_data = '0;
    line     = '0;
    lowhalf  = '0;
    dcount   = 0;
    ack_wait = 0;
    rom_addr = pool[0];

    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("rnd_ok", rom_ok, exp_ok);
      chk("rnd_data", rom_data, exp_data);
      chk("rnd_req", sdram_req, req_pend);
      if (req_pend || in_data) chk("rnd_addr", sdram_addr, {line, 1'b0});

      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) rom_addr = pool[$urandom_range(0, 5)];
      rom_cs    = ($urandom_range(0, 7) != 0);
      sdram_ack = 1'b0;
      sdram_dst = 1'b0;
      sdram_din = 16'($urandom);
      if (req_pend) begin
        if (ack_wait == 0) sdram_ack = 1'b1;
        else ack_wait--;
        sdram_dst = ($urandom_range(0, 3) == 0);
      end else if (in_data) begin
        if ($urandom_range(0, 2) != 0) begin
          sdram_dst = 1'b1;
          sdram_din = mem16(SDW'({line, 1'b0}) + SDW'(dcount));
        end
      end else begin
        sdram_dst = ($urandom_range(0, 5) == 0);
      end

      if (rst) begin
        m_tag.delete();
        m_dat.delete();
        req_pend = 1'b0;
        in_data  = 1'b0;
        exp_ok   = 1'b0;
        exp_data = '0;
        line     = '0;
      end else begin
        m_hit  = 1'b0;
        m_hdat = '0;
        foreach (m_tag[k]) if (m_tag[k] == rom_addr) begin
          m_hit  = 1'b1;
          m_hdat = m_dat[k];
        end
        exp_ok = rom_cs && m_hit;
        if (m_hit) exp_data = m_hdat;
        if (in_data && sdram_dst) begin
          if (dcount == 0) begin
            lowhalf = sdram_din;
            dcount  = 1;
          end else begin
            m_tag.push_back(line);
            m_dat.push_back({sdram_din, lowhalf});
            if (m_tag.size() > NENT) begin
              void'(m_tag.pop_front());
              void'(m_dat.pop_front());
            end
            in_data = 1'b0;
          end
        end else if (req_pend && sdram_ack) begin
          req_pend = 1'b0;
          in_data  = 1'b1;
          dcount   = 0;
        end else if (!req_pend && !in_data && rom_cs && !m_hit) begin
          req_pend = 1'b1;
          line     = rom_addr;
          ack_wait = $urandom_range(0, 3);
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
